// File: rtl/alu_operand_issue.sv
// Operand-issue stage ahead of the add/sub/slt ALU. It holds the register file,
// decodes each instruction, reads operands with write-back bypass and presents
// them through one registered valid/ready output slot.
module alu_operand_issue #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] srca,
  output logic [WIDTH-1:0] srcb,
  output logic [3:0]       alucontrol,
  output logic [4:0]       shamt,
  output logic [AW-1:0]    out_rd,
  output logic             illegal
);
  localparam int NREG = 2**AW;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SLT = 4'b0010;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; while valid is high and ready low, the payload is held stable.

  logic [WIDTH-1:0] regs [NREG];
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [AW-1:0]    rd;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic             dec_ok;
  logic             dec_imm;
  logic [3:0]       dec_ctrl;
  logic             accept;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rs1      = in_instr[15 +: AW];
  assign rs2      = in_instr[20 +: AW];
  assign rd       = in_instr[7 +: AW];
  assign imm_sext = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_ok   = 1'b0;
    dec_imm  = 1'b0;
    dec_ctrl = ALU_ADD;
    case (opcode)
      OP_REG: begin
        if (funct7 == 7'b0000000 && funct3 == 3'b000) begin
          dec_ok = 1'b1;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_ok   = 1'b1;
          dec_ctrl = ALU_SUB;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b010) begin
          dec_ok   = 1'b1;
          dec_ctrl = ALU_SLT;
        end
      end
      OP_IMM: begin
        dec_imm = 1'b1;
        if (funct3 == 3'b000) begin
          dec_ok = 1'b1;
        end else if (funct3 == 3'b010) begin
          dec_ok   = 1'b1;
          dec_ctrl = ALU_SLT;
        end
      end
      default: ;
    endcase
  end

  // A write landing in the same cycle as the read is forwarded; x0 never is.
  always_comb begin
    rs1_val = '0;
    if (rs1 != '0) rs1_val = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
  end

  always_comb begin
    rs2_val = '0;
    if (rs2 != '0) rs2_val = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // An unsupported instruction is still consumed; it only raises illegal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
      srca       <= '0;
      srcb       <= '0;
      alucontrol <= '0;
      shamt      <= '0;
      out_rd     <= '0;
    end else begin
      illegal <= accept && !dec_ok;
      if (accept && dec_ok) begin
        out_valid  <= 1'b1;
        srca       <= rs1_val;
        srcb       <= dec_imm ? imm_sext : rs2_val;
        alucontrol <= dec_ctrl;
        shamt      <= in_instr[24:20];
        out_rd     <= rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: directed scenarios plus a randomized run checked
// against a transaction-level model (register array and expected-output queue).
module tb_alu_operand_issue;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [3:0]  alucontrol;
  logic [4:0]  shamt;
  logic [4:0]  out_rd;
  logic        illegal;

  int total = 0;
  int bad = 0;

  logic [31:0] mregs [32];
  logic        m_valid;
  logic        m_illegal;
  logic [77:0] exp_q [$];

  alu_operand_issue #(.WIDTH(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .srca(srca), .srcb(srcb),
    .alucontrol(alucontrol), .shamt(shamt), .out_rd(out_rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [2:0] f3,
                                         input logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] d);
    return {imm, r1, f3, d, 7'b0010011};
  endfunction

  // 0 add, 1 sub, 2 slt, 3 addi, 4 slti, -1 unsupported
  function automatic int op_kind(input logic [31:0] ins);
    if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'h00) return 0;
    if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'h20) return 1;
    if (ins[6:0] == 7'h33 && ins[14:12] == 3'd2 && ins[31:25] == 7'h00) return 2;
    if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) return 3;
    if (ins[6:0] == 7'h13 && ins[14:12] == 3'd2) return 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    m_valid = 1'b0;
    m_illegal = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle();
    in_valid = 1'b0; in_instr = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    out_ready = 1'b1;
  endtask

  // One clock edge; the model applies the write first, so a same-cycle read sees it.
  task automatic tick();
    logic acc, ordy, wbe;
    logic [31:0] ins, wd, a, b;
    logic [4:0] wr;
    logic [3:0] ctrl;
    int k, v;
    acc = in_valid && (!m_valid || out_ready);
    ordy = out_ready; ins = in_instr; wbe = wb_en; wr = wb_rd; wd = wb_data;
    @(posedge clk);
    if (wbe && wr != 5'd0) mregs[wr] = wd;
    m_illegal = 1'b0;
    if (acc) begin
      k = op_kind(ins);
      if (k < 0) begin
        m_illegal = 1'b1;
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
        a = mregs[ins[19:15]];
        if (k >= 3) begin
          v = int'(ins[31:20]);
          if (v >= 2048) v = v - 4096;
          b = v;
        end else begin
          b = mregs[ins[24:20]];
        end
        ctrl = (k == 1) ? 4'b1000 : (k == 2 || k == 4) ? 4'b0010 : 4'b0000;
        exp_q.push_back({a, b, ctrl, ins[24:20], ins[11:7]});
      end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    total++; if ({srca, srcb, alucontrol, shamt, out_rd} !== 78'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {srca, srcb, alucontrol, shamt, out_rd}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    tick();
    wb_rd = 5'd2; wb_data = 32'd3;
    tick();
    wb_en = 1'b0; in_valid = 1'b1; in_instr = r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", out_valid); end
    total++; if (srca !== 32'd5 || srcb !== 32'd3) begin
      bad++; $display("FAIL add_operands: got %h/%h want 5/3", srca, srcb); end
    total++; if (alucontrol !== 4'b0000 || out_rd !== 5'd3) begin
      bad++; $display("FAIL add_ctrl_rd: got %b/%0d want 0000/3", alucontrol, out_rd); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; out_ready = 1'b0;
    in_instr = r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd4);
    tick();
    in_instr = r_type(7'h00, 5'd1, 5'd1, 3'd0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      wb_en = (i == 1); wb_rd = 5'd1; wb_data = 32'd77;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      total++; if (out_valid !== 1'b1 || srca !== 32'd5 || srcb !== 32'd3 || alucontrol !== 4'b1000 || out_rd !== 5'd4) begin
        bad++; $display("FAIL stall_hold[%0d]: got v=%b a=%h b=%h c=%b rd=%0d want v=1 a=5 b=3 c=1000 rd=4",
                        i, out_valid, srca, srcb, alucontrol, out_rd); end
      tick();
    end
    total++; if (srca !== 32'd5) begin bad++; $display("FAIL stall_after_write: got %h want 5", srca); end
    wb_en = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_rd !== 5'd9 || srca !== 32'd77 || srcb !== 32'd77) begin
      bad++; $display("FAIL release_next: got v=%b rd=%0d a=%h b=%h want v=1 rd=9 a=4d b=4d",
                      out_valid, out_rd, srca, srcb); end
    in_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_imm();
    in_valid = 1'b1; in_instr = i_type(12'hFFF, 5'd1, 3'd0, 5'd5);
    tick();
    in_instr = i_type(12'd7, 5'd1, 3'd2, 5'd6);
    total++; if (srca !== 32'd5 || srcb !== 32'hFFFF_FFFF || alucontrol !== 4'b0000 || out_rd !== 5'd5) begin
      bad++; $display("FAIL addi: got a=%h b=%h c=%b rd=%0d want a=5 b=ffffffff c=0000 rd=5", srca, srcb, alucontrol, out_rd); end
    total++; if (shamt !== 5'h1F) begin bad++; $display("FAIL addi_shamt: got %h want 1f", shamt); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || srcb !== 32'd7 || alucontrol !== 4'b0010 || out_rd !== 5'd6 || shamt !== 5'd7) begin
      bad++; $display("FAIL slti: got v=%b b=%h c=%b rd=%0d sh=%0d want v=1 b=7 c=0010 rd=6 sh=7",
                      out_valid, srcb, alucontrol, out_rd, shamt); end
    tick();
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    in_valid = 1'b1; in_instr = r_type(7'h00, 5'd0, 5'd7, 3'd0, 5'd8);
    tick();
    total++; if (srca !== 32'hDEAD_BEEF || srcb !== 32'd0 || out_rd !== 5'd8) begin
      bad++; $display("FAIL bypass: got a=%h b=%h rd=%0d want a=deadbeef b=0 rd=8", srca, srcb, out_rd); end
    wb_rd = 5'd0; wb_data = 32'd9;
    in_instr = r_type(7'h00, 5'd7, 5'd0, 3'd0, 5'd11);
    tick();
    total++; if (srca !== 32'd0 || srcb !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL x0_bypass: got a=%h b=%h want a=0 b=deadbeef", srca, srcb); end
    wb_en = 1'b0; in_instr = r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd10);
    tick();
    in_valid = 1'b0;
    total++; if (srca !== 32'd0 || srcb !== 32'd0 || out_rd !== 5'd10) begin
      bad++; $display("FAIL x0_read: got a=%h b=%h rd=%0d want 0/0/10", srca, srcb, out_rd); end
    tick();
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_instr = {12'h0, 5'd1, 3'b010, 5'd12, 7'b0000011};
    tick();
    in_instr = r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd12);
    total++; if (illegal !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL load_illegal: got ill=%b v=%b want ill=1 v=0", illegal, out_valid); end
    tick();
    total++; if (illegal !== 1'b0 || out_valid !== 1'b1 || srca !== 32'd5 || srcb !== 32'd3 || out_rd !== 5'd12) begin
      bad++; $display("FAIL after_illegal: got ill=%b v=%b a=%h b=%h rd=%0d want 0/1/5/3/12",
                      illegal, out_valid, srca, srcb, out_rd); end
    in_instr = r_type(7'h20, 5'd2, 5'd1, 3'd2, 5'd13);
    tick();
    in_valid = 1'b0;
    total++; if (illegal !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bad_funct: got ill=%b v=%b want ill=1 v=0", illegal, out_valid); end
    tick();
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_pulse: got %b want 0", illegal); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b0; in_instr = r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_held: got %b want 1", out_valid); end
    reset = 1'b1; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd123;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async: got %b want 0", out_valid); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || srca !== 32'd0 || srcb !== 32'd0) begin
      bad++; $display("FAIL regs_cleared: got v=%b a=%h b=%h want 1/0/0", out_valid, srca, srcb); end
    tick();
  endtask

  task automatic test_random();
    int kind;
    logic [4:0] r1, r2, d;
    logic [77:0] exp_front;
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 6);
      r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 31));
      case (kind)
        0: in_instr = r_type(7'h00, r2, r1, 3'd0, d);
        1: in_instr = r_type(7'h20, r2, r1, 3'd0, d);
        2: in_instr = r_type(7'h00, r2, r1, 3'd2, d);
        3: in_instr = i_type(12'($urandom), r1, 3'd0, d);
        4: in_instr = i_type(12'($urandom), r1, 3'd2, d);
        5: in_instr = {12'($urandom), r1, 3'd2, d, 7'b0000011};
        default: in_instr = r_type(7'h01, r2, r1, 3'd0, d);
      endcase
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      wb_en = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      #1;
      total++; if (in_ready !== (!m_valid || out_ready)) begin
        bad++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, in_ready, !m_valid || out_ready); end
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected[%0d]: got %h want none", n, {srca, srcb, alucontrol, shamt, out_rd});
        end else begin
          exp_front = exp_q[0];
          if ({srca, srcb, alucontrol, shamt, out_rd} !== exp_front) begin
            bad++; $display("FAIL rnd_payload[%0d]: got %h want %h", n, {srca, srcb, alucontrol, shamt, out_rd}, exp_front);
          end
          if (out_ready) exp_q.delete(0);
        end
      end
      tick();
      total++; if (out_valid !== m_valid || illegal !== m_illegal) begin
        bad++; $display("FAIL rnd_flags[%0d]: got v=%b ill=%b want v=%b ill=%b", n, out_valid, illegal, m_valid, m_illegal); end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_stall();
    test_imm();
    test_bypass();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
